prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Serial program loader: the write side of the program memory that the CPU's program counter reads.
- Receives UART 8N1 bytes, decodes a framed load protocol and writes 6-bit instructions into the 32-entry program RAM.
- Holds the CPU halted while a load is in progress; reports the loaded program length and any errors.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 4.
- CMD_START, 8'hA5, command byte that opens a load.
- CMD_END, 8'h5A, command byte that commits a load.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  UART line, idle high, asynchronous to clk.
- we  output  1  program RAM write strobe, one cycle wide.
- waddr  output  5  program RAM write address.
- wdata  output  6  instruction to write.
- halt  output  1  CPU hold; high while loading.
- err  output  1  sticky error flag.
- prog_len  output  6  number of instructions in the last committed load, 0..32.

Behaviour:
- Reset (async, active-high) values: we=0, waddr=0, wdata=0, halt=0, err=0, prog_len=0; RX FSM in R_IDLE, protocol FSM in P_WAIT; bit and sample counters at 0; synchroniser flops at 1.
- rx passes through a 2-FF synchroniser; all uses of rx below mean the synchronised value.
- RX FSM:
  - R_IDLE: on rx=0, go to R_START.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. If rx=1, treat as a glitch and return to R_IDLE. Otherwise go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - R_STOP: sample once after CLKS_PER_BIT cycles. rx=1 produces a one-cycle byte_valid. rx=0 is a framing error: set err, emit no byte, then go to R_IDLE.
- Byte classes:
  - Data byte: bits [7:6]=00.
  - CMD_START or CMD_END: command bytes.
  - Any other value: bad byte.
- Protocol FSM:
  - P_WAIT:
    - CMD_START: waddr=0, write count=0, halt=1, err=0, go to P_LOAD.
    - All other bytes are ignored.
  - P_LOAD:
    - Data byte: in the cycle after byte_valid, we=1, wdata=byte[5:0], waddr=current count. Then count increments, and waddr follows count.
    - 33rd data byte (count already 32): no write, err=1, go to P_ERR.
    - CMD_END: prog_len=count, halt=0, go to P_WAIT.
    - CMD_START: restart the load (count=0, waddr=0, halt stays 1).
    - Bad byte or framing error: err=1, go to P_ERR.
  - P_ERR:
    - halt stays 1; no writes.
    - Only CMD_START recovers (same actions as CMD_START from P_WAIT).
- Count is 6 bits (0..32). waddr is count[4:0] and never wraps into a write.
- prog_len changes only on CMD_END. CMD_END with count=0 gives prog_len=0.
- Reset during a load: halt drops immediately, the partially written RAM is left as is, and prog_len=0.
- A framing error in P_WAIT sets err but does not change state. err is cleared only by CMD_START or rst.
- Latency: we asserts exactly 2 cycles after the clk edge that samples a valid stop bit (1 cycle byte_valid, 1 cycle write).

Test Plan:
- CLKS_PER_BIT=4. Send A5, 01, 3F, 2A, 5A -> writes (0,01),(1,3F),(2,2A), each with a one-cycle we. halt high from A5 until 5A, then prog_len=3, err=0.
- Send A5, then 33 bytes of 00, then 5A -> 32 writes to addresses 0..31. The 33rd byte gives err=1 and halt stays 1. 5A is ignored. A following A5 clears err.
- Send A5, 05, then a frame with stop bit 0, then 5A -> one write (0,05), err=1, halt=1, prog_len unchanged.
- A 1-cycle low glitch on rx while idle -> no byte, no err, FSM back in R_IDLE.
- Send A5, 07, 08, A5, 09, 5A -> writes (0,07),(1,08),(0,09); prog_len=1.
- Assert rst mid-frame during a load -> all outputs return to reset values asynchronously. Sending A5, 11, 5A afterwards works normally: prog_len=1, write (0,11).

Source files
------------

// File: rtl/prog_loader.sv
// Serial program loader: UART 8N1 receiver feeding a framed load protocol that
// writes 6-bit instructions into the 32-entry program RAM and halts the CPU meanwhile.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  CMD_START    = 8'hA5,
  parameter logic [7:0]  CMD_END      = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       we,
  output logic [4:0] waddr,
  output logic [5:0] wdata,
  output logic       halt,
  output logic       err,
  output logic [5:0] prog_len
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
  typedef enum logic [1:0] {PWait, PLoad, PErr} p_state_e;

  logic            sync1_q, sync2_q, rx_s;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            half_done, full_done;

  assign rx_s      = sync2_q;
  assign half_done = (clk_cnt_q == HalfCnt);
  assign full_done = (clk_cnt_q == FullCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      rx_state_q   <= RIdle;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync1_q      <= rx;
      sync2_q      <= sync1_q;
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      RIdle:  if (!rx_s) rx_state_d = RStart;
      RStart: if (half_done) rx_state_d = rx_s ? RIdle : RData;
      RData:  if (full_done && bit_cnt_q == 3'd7) rx_state_d = RStop;
      RStop:  if (full_done) rx_state_d = RIdle;
      default: rx_state_d = RIdle;
    endcase
  end

  always_comb begin
    clk_cnt_d    = clk_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (rx_state_q)
      RIdle: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      RStart: if (half_done) clk_cnt_d = '0;
      RData: if (full_done) begin
        clk_cnt_d = '0;
        shift_d   = {rx_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      RStop: if (full_done) begin
        clk_cnt_d    = '0;
        byte_valid_d = rx_s;
        frame_err_d  = !rx_s;
      end
      default: clk_cnt_d = '0;
    endcase
  end

  p_state_e   p_state_q, p_state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic [4:0] waddr_q, waddr_d;
  logic [5:0] wdata_q, wdata_d;
  logic       halt_q, halt_d;
  logic       err_q, err_d;
  logic [5:0] prog_len_q, prog_len_d;
  logic       is_start, is_end, is_data, is_bad;

  // Command bytes take priority over the data class.
  assign is_start = byte_valid_q && (shift_q == CMD_START);
  assign is_end   = byte_valid_q && (shift_q == CMD_END);
  assign is_data  = byte_valid_q && !is_start && !is_end && (shift_q[7:6] == 2'b00);
  assign is_bad   = byte_valid_q && !is_start && !is_end && !is_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_q  <= PWait;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      halt_q     <= 1'b0;
      err_q      <= 1'b0;
      prog_len_q <= '0;
    end else begin
      p_state_q  <= p_state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      halt_q     <= halt_d;
      err_q      <= err_d;
      prog_len_q <= prog_len_d;
    end
  end

  always_comb begin
    p_state_d = p_state_q;
    unique case (p_state_q)
      PWait: if (is_start) p_state_d = PLoad;
      PLoad: begin
        if (is_end) p_state_d = PWait;
        else if (is_bad || frame_err_q || (is_data && cnt_q == 6'd32)) p_state_d = PErr;
      end
      PErr: if (is_start) p_state_d = PLoad;
      default: p_state_d = PWait;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    we_d       = 1'b0;
    waddr_d    = cnt_q[4:0];
    wdata_d    = wdata_q;
    halt_d     = halt_q;
    err_d      = err_q | frame_err_q;
    prog_len_d = prog_len_q;
    if (is_start) begin
      cnt_d   = '0;
      waddr_d = '0;
      halt_d  = 1'b1;
      err_d   = 1'b0;
    end else if (p_state_q == PLoad) begin
      if (is_data) begin
        if (cnt_q == 6'd32) begin
          err_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          wdata_d = shift_q[5:0];
          waddr_d = cnt_q[4:0];
          cnt_d   = cnt_q + 6'd1;
        end
      end
      if (is_end) begin
        prog_len_d = cnt_q;
        halt_d     = 1'b0;
      end
      if (is_bad) err_d = 1'b1;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign halt     = halt_q;
  assign err      = err_q;
  assign prog_len = prog_len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a byte-level protocol model predicts writes and
// status; a single negedge process checks DUT outputs against it.
module tb_prog_loader;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       we;
  logic [4:0] waddr;
  logic [5:0] wdata;
  logic       halt;
  logic       err;
  logic [5:0] prog_len;

  prog_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .halt     (halt),
    .err      (err),
    .prog_len (prog_len)
  );

  always #5 clk = ~clk;

  typedef enum int {MWait, MLoad, MErr} m_state_e;
  m_state_e   m_st  = MWait;
  int         m_cnt = 0;
  logic       m_halt = 1'b0;
  logic       m_err = 1'b0;
  logic [5:0] m_len = 6'd0;
  logic [10:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  int         req_cnt = 0;
  string      req_name;
  bit         req_lit, req_zero, req_final;
  logic       lit_halt, lit_err;
  logic [5:0] lit_len;

  // Protocol rules at byte granularity; writes are queued as {addr, data}.
  task automatic model_byte(input logic [7:0] b, input bit frame_ok);
    if (!frame_ok) begin
      m_err = 1'b1;
      if (m_st == MLoad) m_st = MErr;
    end else if (b == 8'hA5) begin
      m_st = MLoad; m_cnt = 0; m_halt = 1'b1; m_err = 1'b0;
    end else if (m_st == MLoad) begin
      if (b == 8'h5A) begin
        m_len = 6'(m_cnt); m_halt = 1'b0; m_st = MWait;
      end else if (b[7:6] == 2'b00) begin
        if (m_cnt == 32) begin
          m_err = 1'b1; m_st = MErr;
        end else begin
          exp_q.push_back({5'(m_cnt), b[5:0]});
          m_cnt++;
        end
      end else begin
        m_err = 1'b1; m_st = MErr;
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop = 1'b1);
    model_byte(b, stop);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop;
    cyc(CPB);
    rx = 1'b1;
    cyc(6);
  endtask

  task automatic request(input string name, input bit lit = 1'b0, input logic h = 1'b0,
                         input logic e = 1'b0, input logic [5:0] l = 6'd0,
                         input bit zero = 1'b0, input bit fin = 1'b0);
    req_name  = name;
    req_lit   = lit;
    lit_halt  = h;
    lit_err   = e;
    lit_len   = l;
    req_zero  = zero;
    req_final = fin;
    req_cnt++;
    cyc(1);
  endtask

  int         done_cnt = 0;
  logic [10:0] w;

  always @(negedge clk) begin
    if (!rst && we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got we=1 addr=%0d data=%0h, required no write",
                 waddr, wdata);
      end else begin
        w = exp_q.pop_front();
        if ({waddr, wdata} !== w) begin
          miscompares++;
          $display("FAIL wr: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   waddr, wdata, w[10:6], w[5:0]);
        end
      end
    end
    if (req_cnt != done_cnt) begin
      done_cnt = req_cnt;
      vectors += 3;
      if (halt !== m_halt || err !== m_err || prog_len !== m_len) begin
        miscompares++;
        $display("FAIL %s_model: got halt=%b err=%b len=%0d, required halt=%b err=%b len=%0d",
                 req_name, halt, err, prog_len, m_halt, m_err, m_len);
      end
      if (req_lit) begin
        vectors += 3;
        if (halt !== lit_halt || err !== lit_err || prog_len !== lit_len) begin
          miscompares++;
          $display("FAIL %s_lit: got halt=%b err=%b len=%0d, required halt=%b err=%b len=%0d",
                   req_name, halt, err, prog_len, lit_halt, lit_err, lit_len);
        end
      end
      if (req_zero) begin
        vectors += 3;
        if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 6'd0) begin
          miscompares++;
          $display("FAIL %s_zero: got we=%b addr=%0d data=%0h, required 0/0/0",
                   req_name, we, waddr, wdata);
        end
      end
      if (req_final) begin
        vectors++;
        if (exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL %s_pending: got %0d writes still expected, required 0",
                   req_name, exp_q.size());
        end
      end
    end
  end

  initial begin
    cyc(3);
    request("reset", 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
    rst = 1'b0;
    cyc(4);

    // Idle glitch: one-cycle low pulse must be rejected
    rx = 1'b0;
    cyc(1);
    rx = 1'b1;
    cyc(12);
    request("glitch", 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);

    send(8'hA5);
    request("t1_open", 1'b1, 1'b1, 1'b0, 6'd0);
    send(8'h01); send(8'h3F); send(8'h2A);
    request("t1_mid");
    send(8'h5A);
    request("t1_end", 1'b1, 1'b0, 1'b0, 6'd3);

    send(8'hA5);
    for (int i = 0; i < 32; i++) send(8'h00);
    request("t2_full", 1'b1, 1'b1, 1'b0, 6'd3);
    send(8'h00);
    request("t2_over", 1'b1, 1'b1, 1'b1, 6'd3);
    send(8'h5A);
    request("t2_end_ignored", 1'b1, 1'b1, 1'b1, 6'd3);
    send(8'hA5);
    request("t2_recover", 1'b1, 1'b1, 1'b0, 6'd3);

    send(8'hA5); send(8'h05);
    send(8'h33, 1'b0);
    request("t3_frame", 1'b1, 1'b1, 1'b1, 6'd3);
    send(8'h5A);
    request("t3_end", 1'b1, 1'b1, 1'b1, 6'd3);

    send(8'hA5); send(8'h07); send(8'h08); send(8'hA5); send(8'h09); send(8'h5A);
    request("t5_restart", 1'b1, 1'b0, 1'b0, 6'd1);

    // Framing error outside a load sets err without leaving P_WAIT
    send(8'h12, 1'b0);
    request("t_wait_ferr", 1'b1, 1'b0, 1'b1, 6'd1);
    send(8'h15);
    request("t_wait_data", 1'b1, 1'b0, 1'b1, 6'd1);

    send(8'hA5); send(8'h11);
    request("t6_pre", 1'b1, 1'b1, 1'b0, 6'd1);
    rx = 1'b0;
    cyc(2 * CPB + 2);
    rst = 1'b1;
    m_st = MWait; m_cnt = 0; m_halt = 1'b0; m_err = 1'b0; m_len = 6'd0;
    exp_q.delete();
    request("t6_async_rst", 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
    rx = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(4);
    send(8'hA5); send(8'h11); send(8'h5A);
    request("t6_after", 1'b1, 1'b0, 1'b0, 6'd1, 1'b0, 1'b1);

    cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
